uart_tx_cfg: RTL and testbench

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_tx_pkg.sv | 20 ++
 rtl/uart_tx_fifo.sv | 57 +++++
 rtl/uart_tx_cfg.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the configurable UART transmitter.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic PAR_ODD  = 1'b0;
  localparam logic PAR_EVEN = 1'b1;

  // xor_all is the XOR-reduce of the data word.
  function automatic logic parity_bit(input logic par_typ, input logic xor_all);
    return (par_typ == PAR_EVEN) ? xor_all : ~xor_all;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO buffering words ahead of the UART transmitter.
module uart_tx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign rdata = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with per-frame parity/stop configuration.
// Define UART_TX_FIFO_EN to buffer words in a FIFO_DEPTH-entry FIFO.
module uart_tx_cfg
  import uart_tx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] P_DATA,
  input  logic              DATA_VALID,
  output logic              DATA_READY,
  input  logic              PAR_EN,
  input  logic              PAR_TYP,
  input  logic              STOP2,
  output logic              TX_OUT,
  output logic              Busy,
  output logic [2:0]        dbg_state
);

  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_LAST = CW'(DATA_W - 1);

  if (DATA_W < 5 || DATA_W > 9 || CLKS_PER_BIT < 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("uart_tx_cfg: illegal parameter value");
  end

  state_e            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shr_q, shr_d;
  logic              par_en_q, par_en_d;
  logic              par_bit_q, par_bit_d;
  logic              stop2_q, stop2_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              bit_end, load, word_avail;
  logic [DATA_W-1:0] word_in;

  // Handshake: a word transfers on a rising edge where DATA_VALID and
  // DATA_READY are both 1; the offerer holds P_DATA until then.
`ifdef UART_TX_FIFO_EN
  logic fifo_full, fifo_empty;

  uart_tx_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (DATA_VALID & DATA_READY),
    .pop   (load),
    .wdata (P_DATA),
    .rdata (word_in),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign DATA_READY = reset | ~fifo_full;
  assign word_avail = ~fifo_empty;
`else
  // Without buffering the frame shifter is the only storage, so a word is
  // taken straight into it from IDLE.
  assign DATA_READY = reset | (state_q == IDLE);
  assign word_avail = DATA_VALID & (state_q == IDLE);
  assign word_in    = P_DATA;
`endif

  assign TX_OUT    = tx_q;
  assign Busy      = busy_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shr_d     = shr_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    load      = 1'b0;
    bit_end   = (timer_q == T_LAST);
    timer_d   = (state_q == IDLE || bit_end) ? '0 : timer_q + 1'b1;

    case (state_q)
      IDLE: load = word_avail;
      START: if (bit_end) begin
        state_d   = DATA;
        bit_cnt_d = '0;
        tx_d      = shr_q[0];
      end
      DATA: if (bit_end) begin
        if (bit_cnt_q == C_LAST) begin
          bit_cnt_d = '0;
          if (par_en_q) begin
            state_d = PARITY;
            tx_d    = par_bit_q;
          end else begin
            state_d = STOP;
            tx_d    = 1'b1;
          end
        end else begin
          shr_d     = shr_q >> 1;
          tx_d      = shr_q[1];
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      PARITY: if (bit_end) begin
        state_d = STOP;
        tx_d    = 1'b1;
      end
      STOP: if (bit_end) begin
        // bit_cnt counts completed stop periods when STOP2 is latched.
        if (stop2_q && bit_cnt_q == '0) begin
          bit_cnt_d = CW'(1);
        end else if (word_avail) begin
          load = 1'b1;
        end else begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          tx_d      = 1'b1;
          busy_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d   = START;
      timer_d   = '0;
      bit_cnt_d = '0;
      shr_d     = word_in;
      par_en_d  = PAR_EN;
      par_bit_d = parity_bit(PAR_TYP, ^word_in);
      stop2_d   = STOP2;
      tx_d      = 1'b0;
      busy_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shr_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shr_q     <= shr_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: an 8-bit and a 7-bit instance at 4 clocks per bit.
module tb_uart_tx_cfg;

`ifdef UART_TX_FIFO_EN
  localparam int START_LAT = 2;
`else
  localparam int START_LAT = 1;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] d8_data;
  logic       d8_valid, d8_ready, d8_pe, d8_pt, d8_s2, tx8, busy8;
  logic [2:0] st8;
  logic [6:0] d7_data;
  logic       d7_valid, d7_ready, d7_pe, d7_pt, d7_s2, tx7, busy7;
  logic [2:0] st7;
  logic [15:0] frm7;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] burst_w [6] = '{8'h11, 8'h22, 8'h3C, 8'h5A, 8'hC3, 8'h0F};

  uart_tx_cfg #(.DATA_W(8), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) u_dut8 (
    .clk(clk), .reset(reset), .P_DATA(d8_data), .DATA_VALID(d8_valid),
    .DATA_READY(d8_ready), .PAR_EN(d8_pe), .PAR_TYP(d8_pt), .STOP2(d8_s2),
    .TX_OUT(tx8), .Busy(busy8), .dbg_state(st8)
  );

  uart_tx_cfg #(.DATA_W(7), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) u_dut7 (
    .clk(clk), .reset(reset), .P_DATA(d7_data), .DATA_VALID(d7_valid),
    .DATA_READY(d7_ready), .PAR_EN(d7_pe), .PAR_TYP(d7_pt), .STOP2(d7_s2),
    .TX_OUT(tx7), .Busy(busy7), .dbg_state(st7)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: offer one word at the current negedge; returns at the first start-bit cycle.
  task automatic send8(input logic [7:0] w, input logic pe, input logic pt, input logic s2);
    d8_data  = w;
    d8_pe    = pe;
    d8_pt    = pt;
    d8_s2    = s2;
    d8_valid = 1'b1;
    chk("send_ready", d8_ready, 1);
    @(posedge clk);
    @(negedge clk);
    d8_valid = 1'b0;
    repeat (START_LAT - 1) @(negedge clk);
  endtask

  // Scoreboard for one frame: frm[i] is serial bit i, each held 4 cycles.
  task automatic check_frame8(input logic [15:0] frm, input int nbits, input logic idle_after,
                              input string tag);
    for (int i = 0; i < nbits; i++) begin
      for (int c = 0; c < 4; c++) begin
        chk({tag, "_tx"}, tx8, frm[i]);
        chk({tag, "_busy"}, busy8, 1);
        @(negedge clk);
      end
    end
    if (idle_after) begin
      chk({tag, "_end_tx"}, tx8, 1);
      chk({tag, "_end_busy"}, busy8, 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    d8_data = '0; d8_valid = 0; d8_pe = 0; d8_pt = 0; d8_s2 = 0;
    d7_data = '0; d7_valid = 0; d7_pe = 0; d7_pt = 0; d7_s2 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", tx8, 1);
    chk("rst_busy", busy8, 0);
    chk("rst_ready", d8_ready, 1);
    chk("rst_state", st8, 0);
    reset = 1'b0;
    #1;
    chk("rst_ready_after", d8_ready, 1);
    chk("rst7_state", st7, 0);
    @(negedge clk);

    // 0xA5, no parity, 1 stop: 10 bits, Busy for exactly 40 cycles
    send8(8'hA5, 0, 0, 0);
    chk("a5_state_start", st8, 1);
    check_frame8({6'b0, 1'b1, 8'hA5, 1'b0}, 10, 1, "a5");

    // 0x07 has three ones: odd parity bit 0, even parity bit 1
    send8(8'h07, 1, 0, 0);
    check_frame8({5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 1, "p07_odd");
    send8(8'h07, 1, 1, 0);
    check_frame8({5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 1, "p07_even");
    // 0xFF has eight ones: odd parity bit 1
    send8(8'hFF, 1, 0, 0);
    check_frame8({5'b0, 1'b1, 1'b1, 8'hFF, 1'b0}, 11, 1, "pff_odd");
    // two stop bits
    send8(8'h3C, 0, 0, 1);
    check_frame8({5'b0, 2'b11, 8'h3C, 1'b0}, 11, 1, "s2_3c");

    // configuration changed mid-frame must not affect the frame
    send8(8'h07, 1, 1, 0);
    fork
      check_frame8({5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 1, "cfg_toggle");
      begin
        repeat (10) @(negedge clk);
        d8_pt = 0;
        d8_pe = 0;
        d8_s2 = 1;
      end
    join
    d8_s2 = 0;

`ifdef UART_TX_FIFO_EN
    // six words offered back to back through the FIFO
    fork
      begin
        int k = 0;
        int g = 0;
        logic full_seen = 1'b0;
        while (k < 6 && g < 2000) begin
          d8_data  = burst_w[k];
          d8_valid = 1'b1;
          if (!d8_ready && !full_seen) begin
            full_seen = 1'b1;
            chk("burst_accepted_at_full", k, 5);
          end
          if (d8_ready) k++;
          @(negedge clk);
          g++;
        end
        d8_valid = 1'b0;
        chk("burst_all_accepted", k, 6);
        chk("burst_full_seen", full_seen, 1);
      end
      begin
        int g = 0;
        while (tx8 !== 1'b0 && g < 20) begin
          @(negedge clk);
          g++;
        end
        chk("burst_start_lat", g, 2);
        for (int k = 0; k < 6; k++)
          check_frame8({6'b0, 1'b1, burst_w[k], 1'b0}, 10, (k == 5), "burst");
      end
    join
`else
    // DATA_VALID while DATA_READY is low is ignored
    send8(8'hF0, 1, 1, 0);
    fork
      check_frame8({5'b0, 1'b1, 1'b0, 8'hF0, 1'b0}, 11, 1, "ignore");
      begin
        repeat (6) @(negedge clk);
        d8_data  = 8'h00;
        d8_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
          chk("ignore_ready_low", d8_ready, 0);
          @(negedge clk);
        end
        d8_valid = 1'b0;
      end
    join
    for (int i = 0; i < 8; i++) begin
      chk("ignore_idle_tx", tx8, 1);
      chk("ignore_idle_busy", busy8, 0);
      @(negedge clk);
    end
`endif

    // reset during the 4th data bit aborts the frame and drops pending words
    send8(8'hA5, 0, 0, 0);
`ifdef UART_TX_FIFO_EN
    d8_data  = 8'h99;
    d8_valid = 1'b1;
    @(negedge clk);
    d8_data = 8'h66;
    @(negedge clk);
    d8_valid = 1'b0;
    repeat (15) @(negedge clk);
`else
    repeat (17) @(negedge clk);
`endif
    chk("abort_pre_tx", tx8, 0);
    chk("abort_pre_busy", busy8, 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_tx", tx8, 1);
    chk("abort_busy", busy8, 0);
    chk("abort_state", st8, 0);
    reset = 1'b0;
    #1;
    chk("abort_ready", d8_ready, 1);
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      chk("abort_idle_tx", tx8, 1);
      chk("abort_idle_busy", busy8, 0);
      @(negedge clk);
    end
    send8(8'h3C, 0, 0, 1);
    check_frame8({5'b0, 2'b11, 8'h3C, 1'b0}, 11, 1, "post_abort");

    // 7-bit instance, 0x55, two stop bits
    d7_data  = 7'h55;
    d7_s2    = 1'b1;
    d7_valid = 1'b1;
    chk("d7_ready", d7_ready, 1);
    @(posedge clk);
    @(negedge clk);
    d7_valid = 1'b0;
    repeat (START_LAT - 1) @(negedge clk);
    frm7 = {6'b0, 2'b11, 7'h55, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < 4; c++) begin
        chk("d7_tx", tx7, frm7[i]);
        chk("d7_busy", busy7, 1);
        @(negedge clk);
      end
    end
    chk("d7_end_tx", tx7, 1);
    chk("d7_end_busy", busy7, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
